// File: rtl/gremlin_spawn_ctrl_if.sv
// Bus between the VGA timing / collision side and the gremlin spawn controller.
// The master drives vertical blank, round level and hits; the slave returns strobes and slot status.
interface gremlin_spawn_ctrl_if #(
    parameter int N_GREM = 4
);
    logic              vblnk_in;
    logic              game_on;
    logic [N_GREM-1:0] hit;
    logic              en;
    logic              frame_tick;
    logic [N_GREM-1:0] grem_enable;
    logic [N_GREM-1:0] tomb;
    logic [7:0]        kill_cnt;

    modport master (
        output vblnk_in, game_on, hit,
        input  en, frame_tick, grem_enable, tomb, kill_cnt
    );

    modport slave (
        input  vblnk_in, game_on, hit,
        output en, frame_tick, grem_enable, tomb, kill_cnt
    );
endinterface

// File: rtl/gremlin_spawn_ctrl.sv
// Frame strobes, per-slot spawn/alive/tombstone/respawn sequencing and kill counting
// for a bank of gremlin instances.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no round running; slot hidden
// S_WAIT  | hidden, counting frames down to (re)spawn
// S_ALIVE | visible and moving; a hit sends it to S_TOMB
// S_TOMB  | tombstone shown, counting frames down to respawn wait
module gremlin_spawn_ctrl #(
    parameter int N_GREM         = 4,
    parameter int MOVE_DIV       = 1,
    parameter int TOMB_FRAMES    = 60,
    parameter int RESPAWN_FRAMES = 120,
    parameter int STAGGER_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    gremlin_spawn_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ALIVE,
        S_TOMB
    } slot_state_e;

    slot_state_e       state_q [N_GREM];
    slot_state_e       state_d [N_GREM];
    logic [7:0]        cnt_q   [N_GREM];
    logic [7:0]        cnt_d   [N_GREM];

    logic              vblnk_q;
    logic              game_on_q;
    logic              tick;
    logic              round_start;
    logic [3:0]        div_q;
    logic [N_GREM-1:0] killed;
    logic [3:0]        kill_sum;
    logic [8:0]        kill_total;

    assign tick        = bus.vblnk_in & ~vblnk_q;
    assign round_start = bus.game_on & ~game_on_q;

    // game_on low dominates, then round start, then the per-state behaviour
    always_comb begin
        killed = '0;
        for (int i = 0; i < N_GREM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!bus.game_on) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end else if (round_start) begin
                state_d[i] = S_WAIT;
                cnt_d[i]   = 8'(i * STAGGER_FRAMES);
            end else begin
                case (state_q[i])
                    S_WAIT: begin
                        if (tick) begin
                            if (cnt_q[i] == 8'd0) state_d[i] = S_ALIVE;
                            else                  cnt_d[i]   = cnt_q[i] - 8'd1;
                        end
                    end
                    S_ALIVE: begin
                        if (bus.hit[i]) begin
                            state_d[i] = S_TOMB;
                            cnt_d[i]   = 8'(TOMB_FRAMES - 1);
                            killed[i]  = 1'b1;
                        end
                    end
                    S_TOMB: begin
                        if (tick) begin
                            if (cnt_q[i] == 8'd0) begin
                                state_d[i] = S_WAIT;
                                cnt_d[i]   = 8'(RESPAWN_FRAMES - 1);
                            end else begin
                                cnt_d[i] = cnt_q[i] - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        kill_sum = '0;
        for (int i = 0; i < N_GREM; i++) begin
            kill_sum = kill_sum + 4'(killed[i]);
        end
        kill_total = {1'b0, bus.kill_cnt} + 9'(kill_sum);
    end

    // edge-detect flops reset high so a level already high at release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q         <= 1'b1;
            game_on_q       <= 1'b1;
            div_q           <= '0;
            bus.frame_tick  <= 1'b0;
            bus.en          <= 1'b0;
            bus.grem_enable <= '0;
            bus.tomb        <= '0;
            bus.kill_cnt    <= '0;
            for (int i = 0; i < N_GREM; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            vblnk_q        <= bus.vblnk_in;
            game_on_q      <= bus.game_on;
            bus.frame_tick <= tick;
            bus.en         <= bus.game_on && tick && (div_q == 4'(MOVE_DIV - 1));

            if (!bus.game_on)                   div_q <= '0;
            else if (tick) begin
                if (div_q == 4'(MOVE_DIV - 1)) div_q <= '0;
                else                           div_q <= div_q + 4'd1;
            end

            for (int i = 0; i < N_GREM; i++) begin
                state_q[i]         <= state_d[i];
                cnt_q[i]           <= cnt_d[i];
                bus.grem_enable[i] <= (state_d[i] == S_ALIVE);
                bus.tomb[i]        <= (state_d[i] == S_TOMB);
            end

            if (round_start)              bus.kill_cnt <= '0;
            else if (kill_total > 9'd255) bus.kill_cnt <= 8'hFF;
            else                          bus.kill_cnt <= kill_total[7:0];
        end
    end
endmodule

// File: doc/gremlin_spawn_ctrl.md
Name: gremlin_spawn_ctrl

Overview:
Sequences a bank of N gremlin instances for the game screen.
- Derives the per-frame movement strobe (en) from vertical blanking.
- Drives each instance's grem_enable. While grem_enable is low, the instance relocates to its pseudo-random spawn point on en.
- Runs a per-slot life cycle: staggered spawn, alive, tombstone after a hit, respawn delay.
- Counts kills for the score overlay.

Sits between the VGA timing bus / collision logic and the gremlin instances.

Parameters:
N_GREM, 4, number of gremlin slots (1..8)
MOVE_DIV, 1, frames per en pulse (1..15)
TOMB_FRAMES, 60, frames a tombstone is shown (1..255)
RESPAWN_FRAMES, 120, frames between tombstone removal and respawn (1..255)
STAGGER_FRAMES, 30, initial spawn delay step; slot i waits i*STAGGER_FRAMES frames (product must fit 8 bits)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
vblnk_in  in  1  vertical blank from VGA bus
game_on  in  1  level; high while a round is running
hit  in  N_GREM  per-slot collision (car over gremlin), level or pulse
en  out  1  one-cycle movement strobe to all gremlins
frame_tick  out  1  one-cycle pulse at vblnk_in rising edge
grem_enable  out  N_GREM  per-slot alive flag to gremlin instances
tomb  out  N_GREM  per-slot tombstone display request
kill_cnt  out  8  kills this round, saturating

Behaviour:
- All outputs registered; every output reacts one clk after its cause.
- Reset (wins over everything):
  - en, frame_tick, grem_enable, tomb, kill_cnt = 0.
  - All slots IDLE, counters 0, move divider 0.
  - Edge-detect registers for vblnk and game_on = 1, so no tick or round start fires while the level is already high at reset release.
- frame_tick: high for one cycle when vblnk_in goes 0 to 1. Exactly one per frame.
- en:
  - Move divider counts frame_ticks 0..MOVE_DIV-1 while game_on=1.
  - en pulses on the cycle the divider wraps to 0 (cycle-aligned with frame_tick).
  - MOVE_DIV=1 gives en = frame_tick.
  - game_on=0 holds en=0 and clears the divider.
- Round start is the rising edge of game_on:
  - kill_cnt cleared.
  - Slot i enters WAIT with cnt = i*STAGGER_FRAMES.
- Per-slot FSM; all counting happens only on frame_tick:
  - IDLE: grem_enable=0, tomb=0. Leaves only on round start.
  - WAIT: grem_enable=0, tomb=0.
    - tick with cnt==0: go ALIVE.
    - tick otherwise: cnt-1.
  - ALIVE: grem_enable=1.
    - hit[i]=1 on any cycle: go TOMB, cnt = TOMB_FRAMES-1.
    - A held hit counts once, because the state has left ALIVE.
  - TOMB: grem_enable=0, tomb=1.
    - tick with cnt==0: go WAIT, cnt = RESPAWN_FRAMES-1.
    - tick otherwise: cnt-1.
  - game_on=0 in any state: go IDLE next cycle, grem_enable and tomb cleared.
- hit is ignored in IDLE, WAIT and TOMB.
- kill_cnt:
  - Adds the number of slots moving ALIVE to TOMB in that cycle; simultaneous hits all count.
  - Saturates at 255, e.g. 254+3 = 255.
  - Holds when game_on falls; clears only on reset or round start.
- A hit on the same cycle as a frame_tick that would spawn a slot in WAIT has no effect; the slot goes ALIVE.
- A game_on fall and rise on consecutive cycles is treated as a fresh round start.
- Delays are exact frame counts.
  - Alive to visible again = TOMB_FRAMES + RESPAWN_FRAMES ticks, counted from the first tick after the hit.
  - WAIT with cnt=k goes ALIVE on the (k+1)-th tick.

Test Plan:
Bench parameters: N_GREM=4, MOVE_DIV=2, TOMB_FRAMES=3, RESPAWN_FRAMES=2, STAGGER_FRAMES=2, frame = 20 clk with vblnk high for 4 clk.
- Reset with vblnk_in=1 and game_on=1, then release -> no frame_tick, en, or round start until the next vblnk rise; grem_enable=0000.
- game_on rises, then 6 frames -> grem_enable: 0001 after tick 1, 0011 after tick 3, 0111 after tick 5; en pulses on ticks 2, 4, 6 only.
- hit[0] pulsed while slot 0 is ALIVE -> next cycle grem_enable[0]=0, tomb[0]=1, kill_cnt=1; tomb[0] clears after 3 ticks; grem_enable[0]=1 after 2 more ticks.
- hit held at 1111 for 10 cycles with all slots alive -> kill_cnt +4 once; with kill_cnt preset to 253 -> 255.
- hit[1] held high through TOMB and WAIT -> no extra kills; on respawn the still-high hit kills immediately (kill_cnt +1 one cycle after grem_enable[1] rises).
- game_on drops mid-TOMB -> next cycle grem_enable=0000, tomb=0000, en silent, kill_cnt held; game_on rises again -> kill_cnt=0 and the stagger sequence restarts.
